// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared decode definitions for pipelined_decode.
//   Opcode constants, the halt word, the ALU control encoding, the FSM
//   state type, the decoded control bundle and the pure decode helpers
//   (control bundle and 32-bit immediate) used by the decode stage.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10   // LUI: result is the immediate operand
    } alu_ctrl_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        alu_ctrl_t  alu_ctrl;
        logic [2:0] mem_ctrl;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // alt selects SUB (funct3=000) or SRA (funct3=101).
    function automatic alu_ctrl_t alu_op(input logic [2:0] f3, input logic alt);
        alu_ctrl_t a;
        case (f3)
            3'b000:  a = alt ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = alt ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    // Jumps write the link register and use an immediate operand; the
    // branch flag is reserved for conditional branches.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_ADD;
        case (instr[6:0])
            OP_R: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = alu_op(instr[14:12], instr[30]);
            end
            OP_IMM: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                // bit 30 is immediate data except for the shift-right pair
                c.alu_ctrl  = alu_op(instr[14:12], (instr[14:12] == 3'b101) && instr[30]);
            end
            OP_LOAD: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_ctrl   = instr[14:12];
            end
            OP_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.mem_ctrl  = instr[14:12];
            end
            OP_BRANCH: begin
                c.branch   = 1'b1;
                c.alu_ctrl = ALU_SUB;
            end
            OP_JAL, OP_JALR, OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_PASSB;
            end
            default: ;
        endcase
        return c;
    endfunction

    // 32-bit sign-extended immediate; widened to WIDTH by the caller.
    function automatic logic [31:0] decode_imm(input logic [31:0] i);
        logic [31:0] imm;
        case (i[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm = {{20{i[31]}}, i[31:20]};
            OP_STORE:                 imm = {{20{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = {i[31:12], 12'b0};
            OP_JAL:                   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:                  imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/pipelined_decode_if.sv
// pipelined_decode_if -- instruction-in / decoded-bundle-out stream bus.
//   in_*  : fetch -> decode valid/ready stream (instr, pc)
//   out_* : decode -> execute valid/ready stream (operands, imm, rd, controls)
//   master: upstream/downstream environment; slave: the decode stage.
interface pipelined_decode_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [WIDTH-1:0] in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_rs1_data;
    logic [WIDTH-1:0] out_rs2_data;
    logic [WIDTH-1:0] out_imm;
    logic [4:0]       out_rd;
    logic [3:0]       out_alu_ctrl;
    logic [2:0]       out_mem_ctrl;
    logic             out_alu_src;
    logic             out_branch;
    logic             out_mem_read;
    logic             out_mem_write;
    logic             out_mem_to_reg;
    logic             out_reg_write;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_alu_ctrl, out_mem_ctrl, out_alu_src, out_branch,
               out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_alu_ctrl, out_mem_ctrl, out_alu_src, out_branch,
               out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write
    );

endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass -- architectural register file, two combinational read
// ports and one synchronous write port.
//   clk, rst              : clock, sync active-high reset (clears all regs)
//   wb_en/wb_addr/wb_data : write port; x0 and addresses >= NUM_REGS ignored
//   rs1/rs2_addr -> _data : read ports; x0 and out-of-range read as zero
// Optional macro DECODE_WB_BYPASS_EN: a read hitting the same-cycle valid
// write returns wb_data; otherwise it returns the pre-write value.
module regfile_bypass #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             wb_ok;

    assign wb_ok = wb_en && (wb_addr != 5'd0) && (int'(wb_addr) < NUM_REGS);

    // regs[0] stays zero forever; reads never select it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst)
                regs[i] <= '0;
            else if (wb_ok && (i != 0) && (wb_addr == 5'(i)))
                regs[i] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_addr == 5'(i)) rs1_data = regs[i];
            if (rs2_addr == 5'(i)) rs2_data = regs[i];
        end
`ifdef DECODE_WB_BYPASS_EN
        if (wb_ok && (rs1_addr == wb_addr)) rs1_data = wb_data;
        if (wb_ok && (rs2_addr == wb_addr)) rs2_data = wb_data;
`endif
    end

endmodule

// File: rtl/pipelined_decode.sv
// pipelined_decode -- single-stage RV32I decode with valid/ready handshake,
// load-use stall, flush and a sticky HALT state.
//   clk, rst          : clock, sync active-high reset
//   flush             : kill the output register and drop this cycle's input
//   ex_mem_read/ex_rd : load in EX; stall if it feeds rs1/rs2
//   wb_en/addr/data   : register-file write port (works in every state)
//   halted            : 1 once the halt word 0xFFFFFFFF has been accepted
//   bus (slave)       : in_* instruction stream, out_* decoded bundle
// Optional macro DECODE_WB_BYPASS_EN enables write-to-read forwarding.
module pipelined_decode
    import riscv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             halted,
    pipelined_decode_if.slave bus
);

    state_t           state;
    logic [4:0]       rs1_addr, rs2_addr;
    logic [WIDTH-1:0] rs1_data, rs2_data;
    logic             hazard, out_free, in_fire;
    ctrl_t            ctrl_d, ctrl_q;
    logic [31:0]      imm32;

    logic             valid_q;
    logic [WIDTH-1:0] pc_q, rs1_q, rs2_q, imm_q;
    logic [4:0]       rd_q;

    assign rs1_addr = bus.in_instr[19:15];
    assign rs2_addr = bus.in_instr[24:20];

    // Load-use: the EX load result is not yet available for either source.
    assign hazard   = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == rs1_addr) || (ex_rd == rs2_addr));
    assign out_free = !valid_q || bus.out_ready;
    assign bus.in_ready = (state == ST_RUN) && !hazard && !flush && out_free;
    assign in_fire  = bus.in_valid && bus.in_ready;

    assign ctrl_d = decode_ctrl(bus.in_instr);
    assign imm32  = decode_imm(bus.in_instr);

    regfile_bypass #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    // in_ready already excludes flush, so in_fire implies no flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RUN;
            halted  <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_fire) begin
            if (bus.in_instr == HALT_WORD) begin
                // halt word is consumed but never presented downstream
                state   <= ST_HALT;
                halted  <= 1'b1;
                valid_q <= 1'b0;
            end else begin
                valid_q <= 1'b1;
                pc_q    <= bus.in_pc;
                rs1_q   <= rs1_data;
                rs2_q   <= rs2_data;
                imm_q   <= WIDTH'($signed(imm32));
                rd_q    <= bus.in_instr[11:7];
                ctrl_q  <= ctrl_d;
            end
        end else if (out_free) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_rs1_data   = rs1_q;
    assign bus.out_rs2_data   = rs2_q;
    assign bus.out_imm        = imm_q;
    assign bus.out_rd         = rd_q;
    assign bus.out_alu_ctrl   = ctrl_q.alu_ctrl;
    assign bus.out_mem_ctrl   = ctrl_q.mem_ctrl;
    assign bus.out_alu_src    = ctrl_q.alu_src;
    assign bus.out_branch     = ctrl_q.branch;
    assign bus.out_mem_read   = ctrl_q.mem_read;
    assign bus.out_mem_write  = ctrl_q.mem_write;
    assign bus.out_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.out_reg_write  = ctrl_q.reg_write;

endmodule

// File: tb/tb_pipelined_decode.sv
// tb_pipelined_decode -- directed + randomized check of pipelined_decode
// against a behavioural decode model; a second NUM_REGS=16 instance shares
// the stimulus for the out-of-range register check.
module tb_pipelined_decode;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, ex_mem_read, wb_en;
    logic [4:0]  ex_rd, wb_addr;
    logic [31:0] wb_data;
    logic        halted, halted16;
    int          checks = 0;
    int          failures = 0;

    pipelined_decode_if #(.WIDTH(32)) bus ();
    pipelined_decode_if #(.WIDTH(32)) bus16 ();

    assign bus16.in_valid  = bus.in_valid;
    assign bus16.in_instr  = bus.in_instr;
    assign bus16.in_pc     = bus.in_pc;
    assign bus16.out_ready = bus.out_ready;

    pipelined_decode #(.WIDTH(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted), .bus(bus));

    pipelined_decode #(.WIDTH(32), .NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .halted(halted16), .bus(bus16));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [2:0]  mem;
        logic        alu_src, branch, mr, mw, m2r, rw;
    } dec_t;

    logic [31:0] rf [32];
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
    bit          bypass;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_type(input int imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1, f3, rd, op};
    endfunction

    // Reference value of a register read as seen during the cycle a write is driven.
    function automatic logic [31:0] rd_model(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bypass && wb_en && wb_addr == a) return wb_data;
        return rf[a];
    endfunction

    function automatic logic [3:0] alu_model(input logic [2:0] f3, input logic alt);
        logic [3:0] base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (alt && f3 == 3'd0) return ALU_SUB;
        if (alt && f3 == 3'd5) return ALU_SRA;
        return base[f3];
    endfunction

    function automatic dec_t model(input logic [31:0] ins, input logic [31:0] pc);
        dec_t d;
        logic [2:0]  f3 = ins[14:12];
        logic [31:0] ihi;
        ihi = 32'($signed(ins) >>> 20);
        d = '{pc: pc, rs1: rd_model(ins[19:15]), rs2: rd_model(ins[24:20]), imm: 32'h0,
              rd: ins[11:7], alu: ALU_ADD, mem: 3'd0, alu_src: 1'b0, branch: 1'b0,
              mr: 1'b0, mw: 1'b0, m2r: 1'b0, rw: 1'b0};
        case (ins[6:0])
            7'h33: begin d.rw = 1; d.alu = alu_model(f3, ins[30]); end
            7'h13: begin d.rw = 1; d.alu_src = 1; d.imm = ihi; d.alu = alu_model(f3, f3 == 5 && ins[30]); end
            7'h03: begin d.rw = 1; d.alu_src = 1; d.mr = 1; d.m2r = 1; d.mem = f3; d.imm = ihi; end
            7'h23: begin d.alu_src = 1; d.mw = 1; d.mem = f3; d.imm = (ihi & ~32'h1F) | 32'(ins[11:7]); end
            7'h63: begin
                d.branch = 1; d.alu = ALU_SUB;
                d.imm = (ihi & ~32'hFFF) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'h6F: begin
                d.rw = 1; d.alu_src = 1;
                d.imm = (ihi & ~32'hFFFFF) | (ins & 32'h000FF000) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            7'h67: begin d.rw = 1; d.alu_src = 1; d.imm = ihi; end
            7'h37: begin d.rw = 1; d.alu_src = 1; d.alu = ALU_PASSB; d.imm = ins & 32'hFFFFF000; end
            7'h17: begin d.rw = 1; d.alu_src = 1; d.imm = ins & 32'hFFFFF000; end
            default: ;
        endcase
        return d;
    endfunction

    task automatic check_out(input string tag, input dec_t e);
        chk({tag, ".pc"},  bus.out_pc, e.pc);
        chk({tag, ".rs1"}, bus.out_rs1_data, e.rs1);
        chk({tag, ".rs2"}, bus.out_rs2_data, e.rs2);
        chk({tag, ".imm"}, bus.out_imm, e.imm);
        chk({tag, ".rd"},  bus.out_rd, e.rd);
        chk({tag, ".ctl"},
            {bus.out_alu_ctrl, bus.out_mem_ctrl, bus.out_alu_src, bus.out_branch, bus.out_mem_read,
             bus.out_mem_write, bus.out_mem_to_reg, bus.out_reg_write},
            {e.alu, e.mem, e.alu_src, e.branch, e.mr, e.mw, e.m2r, e.rw});
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        tick();
        if (a != 0) rf[a] = d;
        wb_en = 0;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid = 1; bus.in_instr = ins; bus.in_pc = pc;
    endtask

    initial begin
        dec_t        e, held, exp_q;
        bit          exp_v, exp_rdy;
        logic [31:0] add775, lw, addi, ins;

`ifdef DECODE_WB_BYPASS_EN
        bypass = 1;
`else
        bypass = 0;
`endif
        foreach (rf[i]) rf[i] = 32'h0;
        add775 = r_type(7'd0, 5'd6, 5'd5, 3'd0, 5'd7, 7'h33);
        lw     = i_type(-4, 5'd2, 3'd2, 5'd1, 7'h03);
        addi   = i_type(1, 5'd3, 3'd0, 5'd4, 7'h13);

        // reset
        rst = 1; flush = 0; ex_mem_read = 0; ex_rd = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 1;
        tick(); tick();
        chk("rst.valid", bus.out_valid, 0);
        chk("rst.halted", halted, 0);
        chk("rst.outs", {bus.out_pc, bus.out_imm, bus.out_rd, bus.out_reg_write}, 0);
        rst = 0; #1;
        chk("rst.in_ready", bus.in_ready, 1);

        // basic ADD
        wb(5'd5, 32'h1234); wb(5'd6, 32'h10);
        offer(add775, 32'h100); e = model(add775, 32'h100);
        tick(); bus.in_valid = 0;
        chk("add.valid", bus.out_valid, 1);
        chk("add.rs1", bus.out_rs1_data, 32'h1234);
        chk("add.rs2", bus.out_rs2_data, 32'h10);
        chk("add.rd_rw", {bus.out_rd, bus.out_reg_write}, {5'd7, 1'b1});
        check_out("add", e);

        // load-use stall
        ex_mem_read = 1; ex_rd = 5; offer(add775, 32'h104); #1;
        chk("haz.in_ready", bus.in_ready, 0);
        tick();
        chk("haz.bubble", bus.out_valid, 0);
        ex_mem_read = 0; #1;
        chk("haz.release", bus.in_ready, 1);
        tick(); bus.in_valid = 0;
        chk("haz.valid", bus.out_valid, 1);
        check_out("haz", model(add775, 32'h104));

        // backpressure holding LW
        offer(lw, 32'h108); held = model(lw, 32'h108);
        tick();
        bus.out_ready = 0; offer(addi, 32'h10C);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp.in_ready", bus.in_ready, 0);
            tick();
            chk("bp.valid", bus.out_valid, 1);
            chk("bp.imm_mem", {bus.out_imm, bus.out_mem_ctrl}, {32'hFFFF_FFFC, 3'b010});
            check_out("bp", held);
        end
        bus.out_ready = 1; e = model(addi, 32'h10C); #1;
        chk("bp.release", bus.in_ready, 1);
        tick(); bus.in_valid = 0;
        check_out("bp.next", e);
        tick();
        chk("bubble.valid", bus.out_valid, 0);

        // same-cycle writeback vs read
        wb(5'd3, 32'h55);
        wb_en = 1; wb_addr = 3; wb_data = 32'hABCD; offer(addi, 32'h110);
        e = model(addi, 32'h110);
        tick(); wb_en = 0; bus.in_valid = 0; rf[3] = 32'hABCD;
        chk("wbbyp.rs1", bus.out_rs1_data, bypass ? 32'hABCD : 32'h55);
        check_out("wbbyp", e);

        // out-of-range register on the 16-entry instance
        wb(5'd20, 32'h7);
        ins = r_type(7'd0, 5'd0, 5'd20, 3'd0, 5'd1, 7'h33);
        offer(ins, 32'h114);
        tick(); bus.in_valid = 0;
        chk("r16.valid", bus16.out_valid, 1);
        chk("r16.rs1", bus16.out_rs1_data, 0);
        chk("r32.rs1", bus.out_rs1_data, 32'h7);

        // randomized traffic
        tick(); exp_v = 0;
        for (int n = 0; n < 300; n++) begin
            ins = {$urandom() & 32'hFFFF_FF80} | 32'(ops[$urandom_range(0, 9)]);
            offer(ins, $urandom());
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            ex_mem_read = ($urandom_range(0, 7) == 0); ex_rd = 5'($urandom());
            flush = ($urandom_range(0, 15) == 0);
            wb_en = $urandom_range(0, 1); wb_addr = 5'($urandom()); wb_data = $urandom();
            exp_rdy = !flush && (!exp_v || bus.out_ready) &&
                      !(ex_mem_read && ex_rd != 0 && (ex_rd == ins[19:15] || ex_rd == ins[24:20]));
            #1 chk("rnd.in_ready", bus.in_ready, exp_rdy);
            if (flush) exp_v = 0;
            else if (bus.in_valid && exp_rdy) begin exp_v = 1; exp_q = model(ins, bus.in_pc); end
            else if (!exp_v || bus.out_ready) exp_v = 0;
            tick();
            if (wb_en && wb_addr != 0) rf[wb_addr] = wb_data;
            chk("rnd.valid", bus.out_valid, exp_v);
            if (exp_v) check_out("rnd", exp_q);
        end
        bus.in_valid = 0; flush = 0; ex_mem_read = 0; wb_en = 0; bus.out_ready = 1;
        tick();

        // flush kills held output and a same-cycle halt word
        offer(add775, 32'h200); tick();
        bus.out_ready = 0; flush = 1; offer(HALT_WORD, 32'h204); #1;
        chk("fl.in_ready", bus.in_ready, 0);
        tick(); flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        chk("fl.valid", bus.out_valid, 0);
        chk("fl.halted", halted, 0);

        // halt
        offer(HALT_WORD, 32'h208); tick(); bus.in_valid = 0;
        chk("halt.halted", halted, 1);
        chk("halt.valid", bus.out_valid, 0);
        offer(add775, 32'h20C); #1;
        chk("halt.in_ready", bus.in_ready, 0);
        tick(); bus.in_valid = 0;
        chk("halt.stay", {halted, bus.out_valid}, 2'b10);

        // reset exits HALT, clears registers and a held output
        rst = 1; tick(); rst = 0;
        chk("rst2.halted", halted, 0);
        offer(add775, 32'h300); tick();
        chk("rst2.rs1", bus.out_rs1_data, 0);
        bus.out_ready = 0; tick();
        chk("rst2.held", bus.out_valid, 1);
        rst = 1; tick(); rst = 0; bus.in_valid = 0; bus.out_ready = 1;
        chk("rst2.drop", {bus.out_valid, bus.out_pc}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
